// File: rtl/agc_timepulse_gen_if.sv
// Control/status bundle for agc_timepulse_gen.
// slave modport: sequencer side (samples restart/halt/step, drives timepulses and counters).
// master modport: controller/bench side (drives restart/halt/step, observes everything else).
interface agc_timepulse_gen_if #(
   parameter int CNT_W = 16
);
   logic             restart;        // synchronous restart request, level-sampled
   logic             halt;           // monitor stop request, honoured at MCT end
   logic             step;           // single-MCT advance while stopped (rising edge)
   logic [11:0]      t;              // one-hot timepulse, bit0 = T01
   logic             phs2;           // mid-timepulse phase strobe
   logic             phs4;           // last-subphase phase strobe
   logic             mct_end;        // last subphase of T12
   logic             stopped;        // sequencer parked
   logic [CNT_W-1:0] mct_count;      // completed MCTs, wrapping
   logic [3:0]       restart_count;  // restarts taken, saturating

   modport slave (
      input  restart, halt, step,
      output t, phs2, phs4, mct_end, stopped, mct_count, restart_count
   );

   modport master (
      output restart, halt, step,
      input  t, phs2, phs4, mct_end, stopped, mct_count, restart_count
   );
endinterface

// File: rtl/agc_timepulse_gen.sv
// Master timing sequencer: subphases -> one-hot timepulses T01..T12 per MCT, PHS2/PHS4
// strobes, restart/halt/step control and debug counters.
// Ports: clk, rst (async active-high), bus (agc_timepulse_gen_if.slave); all outputs
// come from registers or pure decodes of registers.
module agc_timepulse_gen #(
   parameter int NUM_SUB = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   agc_timepulse_gen_if.slave   bus
);
   localparam int SUB_W = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(NUM_SUB - 1);
   localparam logic [SUB_W-1:0] SUB_PHS2 = SUB_W'(NUM_SUB / 2 - 1);

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_STOPPED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [SUB_W-1:0]   sub_q, sub_d;
   logic [11:0]        t_q, t_d;
   logic [CNT_W-1:0]   mct_q, mct_d;
   logic [3:0]         rcnt_q, rcnt_d;
   logic               step_prev_q;
   logic               restart_prev_q;

   logic               last_sub;
   logic               mct_end_w;
   logic               step_edge;

   assign last_sub  = (sub_q == SUB_LAST);
   assign mct_end_w = (state_q == ST_RUN) && t_q[11] && last_sub;
   assign step_edge = bus.step && !step_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         sub_q          <= '0;
         t_q            <= 12'h001;
         mct_q          <= '0;
         rcnt_q         <= '0;
         step_prev_q    <= 1'b0;
         restart_prev_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         sub_q          <= sub_d;
         t_q            <= t_d;
         mct_q          <= mct_d;
         rcnt_q         <= rcnt_d;
         step_prev_q    <= bus.step;
         restart_prev_q <= bus.restart;
      end
   end

   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      t_d     = t_q;
      mct_d   = mct_q;
      rcnt_d  = rcnt_q;

      if (bus.restart) begin
         // Restart overrides everything, including a coincident MCT boundary:
         // the interrupted MCT is not counted and halt is not honoured.
         state_d = ST_RUN;
         sub_d   = '0;
         t_d     = 12'h001;
         if (!restart_prev_q && (rcnt_q != 4'hF)) begin
            rcnt_d = rcnt_q + 4'd1;
         end
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (last_sub) begin
                  sub_d = '0;
                  // Rotate left; T12 wraps back to T01.
                  t_d   = {t_q[10:0], t_q[11]};
                  if (mct_end_w) begin
                     mct_d = mct_q + 1'b1;
                     if (bus.halt) begin
                        state_d = ST_STOPPED;
                        t_d     = '0;
                     end
                  end
               end else begin
                  sub_d = sub_q + 1'b1;
               end
            end
            ST_STOPPED: begin
               // A step edge launches one MCT; halt still held at its end parks again.
               if (!bus.halt || step_edge) begin
                  state_d = ST_RUN;
                  sub_d   = '0;
                  t_d     = 12'h001;
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   assign bus.t             = t_q;
   assign bus.phs2          = (state_q == ST_RUN) && (sub_q == SUB_PHS2);
   assign bus.phs4          = (state_q == ST_RUN) && last_sub;
   assign bus.mct_end       = mct_end_w;
   assign bus.stopped       = (state_q == ST_STOPPED);
   assign bus.mct_count     = mct_q;
   assign bus.restart_count = rcnt_q;
endmodule

// File: tb/tb_agc_timepulse_gen.sv
module tb_agc_timepulse_gen;
   localparam int NUM_SUB = 4;
   localparam int CNT_W   = 6;   // narrow counter so the wrap is reached in a short run
   localparam int MCT_LEN = 12 * NUM_SUB;

   typedef struct packed {
      logic [11:0]      t;
      logic             phs2;
      logic             phs4;
      logic             mct_end;
      logic             stopped;
      logic [CNT_W-1:0] mct_count;
      logic [3:0]       restart_count;
   } obs_t;

   logic clk;
   logic rst;

   agc_timepulse_gen_if #(.CNT_W(CNT_W)) bus ();

   agc_timepulse_gen #(.NUM_SUB(NUM_SUB), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   obs_t exp_q[$];

   // Reference model: position within the MCT as a plain cycle index.
   bit running;
   int pos;
   int m_mct;
   int m_rcnt;
   bit m_step_prev;
   bit m_rst_prev;
   int wraps;

   function automatic obs_t model_obs();
      obs_t o;
      o.t             = running ? 12'(1 << (pos / NUM_SUB)) : 12'h000;
      o.phs2          = running && (pos % NUM_SUB == NUM_SUB / 2 - 1);
      o.phs4          = running && (pos % NUM_SUB == NUM_SUB - 1);
      o.mct_end       = running && (pos == MCT_LEN - 1);
      o.stopped       = !running;
      o.mct_count     = CNT_W'(m_mct);
      o.restart_count = 4'(m_rcnt);
      return o;
   endfunction

   task automatic model_reset();
      running     = 1'b1;
      pos         = 0;
      m_mct       = 0;
      m_rcnt      = 0;
      m_step_prev = 1'b0;
      m_rst_prev  = 1'b0;
   endtask

   task automatic model_clock(input bit r, input bit h, input bit s);
      if (r) begin
         running = 1'b1;
         pos     = 0;
         if (!m_rst_prev && m_rcnt < 15) m_rcnt++;
      end else if (running) begin
         if (pos == MCT_LEN - 1) begin
            m_mct = (m_mct + 1) % (1 << CNT_W);
            if (m_mct == 0) wraps++;
            pos = 0;
            if (h) running = 1'b0;
         end else begin
            pos++;
         end
      end else if (!h || (s && !m_step_prev)) begin
         running = 1'b1;
         pos     = 0;
      end
      m_step_prev = s;
      m_rst_prev  = r;
   endtask

   function automatic obs_t dut_obs();
      obs_t o;
      o.t             = bus.t;
      o.phs2          = bus.phs2;
      o.phs4          = bus.phs4;
      o.mct_end       = bus.mct_end;
      o.stopped       = bus.stopped;
      o.mct_count     = bus.mct_count;
      o.restart_count = bus.restart_count;
      return o;
   endfunction

   task automatic check_now(input string name, input obs_t exp_o);
      obs_t got;
      got = dut_obs();
      checks++;
      if (got !== exp_o) begin
         failures++;
         $display("FAIL %s cyc=%0d got t=%h p2=%b p4=%b end=%b stp=%b mct=%0d rc=%0d exp t=%h p2=%b p4=%b end=%b stp=%b mct=%0d rc=%0d",
                  name, cyc, got.t, got.phs2, got.phs4, got.mct_end, got.stopped, got.mct_count,
                  got.restart_count, exp_o.t, exp_o.phs2, exp_o.phs4, exp_o.mct_end, exp_o.stopped,
                  exp_o.mct_count, exp_o.restart_count);
      end
   endtask

   // Monitor: one expected observation per clock, compared just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) check_now("scoreboard", exp_q.pop_front());
      end
   end

   // Drive one clock's inputs on the falling edge and queue the post-edge expectation.
   task automatic cycle(input bit r, input bit h, input bit s);
      @(negedge clk);
      bus.restart = r;
      bus.halt    = h;
      bus.step    = s;
      model_clock(r, h, s);
      exp_q.push_back(model_obs());
   endtask

   // Asynchronous reset pulse between edges; outputs must change before the next edge.
   task automatic async_reset();
      obs_t e;
      @(negedge clk);
      bus.restart = 1'b0;
      bus.halt    = 1'b0;
      bus.step    = 1'b0;
      #1 rst = 1'b1;
      #1;
      model_reset();
      e = model_obs();
      check_now("async_reset", e);
      #1 rst = 1'b0;
      model_clock(1'b0, 1'b0, 1'b0);
      exp_q.push_back(model_obs());
   endtask

   initial begin
      int guard;
      wraps       = 0;
      rst         = 1'b1;
      bus.restart = 1'b0;
      bus.halt    = 1'b0;
      bus.step    = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_now("reset_state", model_obs());
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(model_obs());
      model_clock(1'b0, 1'b0, 1'b0);
      exp_q.pop_back();
      exp_q.push_back(model_obs());

      // Free run.
      repeat (100) cycle(0, 0, 0);

      // Halt raised mid-MCT: current MCT completes, then parked.
      guard = 0;
      while (!(running && pos == 9) && guard < 200) begin cycle(0, 0, 0); guard++; end
      repeat (250) cycle(0, 1, 0);

      // Single step with halt held: exactly one MCT.
      cycle(0, 1, 1);
      repeat (70) cycle(0, 1, 0);
      // Step held high: still only one MCT.
      repeat (300) cycle(0, 1, 1);
      repeat (5) cycle(0, 1, 0);

      // Restart during T07 sub2, then held for 5 clocks.
      guard = 0;
      while (!(running && pos == 6 * NUM_SUB + 2) && guard < 200) begin cycle(0, 0, 0); guard++; end
      cycle(1, 0, 0);
      repeat (10) cycle(0, 0, 0);
      repeat (5) cycle(1, 0, 0);
      repeat (10) cycle(0, 0, 0);

      // Restart coincident with the MCT boundary while halt is requested.
      guard = 0;
      while (!(running && pos == MCT_LEN - 1) && guard < 200) begin cycle(0, 1, 0); guard++; end
      cycle(1, 1, 0);
      repeat (60) cycle(0, 0, 0);

      // Saturate restart_count.
      repeat (20) begin cycle(1, 0, 0); cycle(0, 0, 0); end

      // Async reset in the middle of T05.
      guard = 0;
      while (!(running && pos == 4 * NUM_SUB + 1) && guard < 200) begin cycle(0, 0, 0); guard++; end
      async_reset();

      // Long free run to wrap mct_count.
      repeat (70 * MCT_LEN) cycle(0, 0, 0);

      // Randomised mix of halt/step/restart.
      repeat (5000) cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) == 0);
      repeat (5) cycle(0, 0, 0);

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0 || wraps == 0) begin
         failures++;
         $display("FAIL drain pending=%0d wraps=%0d required pending=0 wraps>0", exp_q.size(), wraps);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
